// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: circular buffer with occupancy counter, registered read
// data, per-request ack/err pulses and almost-full/almost-empty thresholds.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2,
    parameter int CLEAR_DOUT = 1,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [CW-1:0]         data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]         head_r;
    logic [PW-1:0]         tail_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nxt_s;
    logic [DATA_WIDTH-1:0] dout_nxt_s;
    logic                  rd_ok_s;
    logic                  wr_ok_s;

    // Request qualification, next occupancy and next read data.
    always_comb begin
        rd_ok_s     = 1'b0;
        wr_ok_s     = 1'b0;
        count_nxt_s = count_r;
        dout_nxt_s  = d_out;
        if (rd_en && (count_r != CW'(0))) begin
            rd_ok_s = 1'b1;
        end else begin
            rd_ok_s = 1'b0;
        end
        // A read on a full FIFO frees a slot for the write at the same edge.
        if (wr_en && ((count_r != CW'(DEPTH)) || rd_ok_s)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (rd_ok_s) begin
            dout_nxt_s = mem_r[head_r];
        end else if (CLEAR_DOUT != 0) begin
            dout_nxt_s = {DATA_WIDTH{1'b0}};
        end else begin
            dout_nxt_s = d_out;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[tail_r] <= d_in;
        end
    end

    // Pointers, occupancy, read data and request status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            d_out   <= {DATA_WIDTH{1'b0}};
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            head_r  <= rd_ok_s ? head_r + PW'(1) : head_r;
            tail_r  <= wr_ok_s ? tail_r + PW'(1) : tail_r;
            count_r <= count_nxt_s;
            d_out   <= dout_nxt_s;
            wr_ack  <= wr_ok_s;
            wr_err  <= (wr_en == 1'b1) && !wr_ok_s;
            rd_ack  <= rd_ok_s;
            rd_err  <= (rd_en == 1'b1) && !rd_ok_s;
        end
    end

    // Status flags derive only from the occupancy register.
    assign data_count   = count_r;
    assign full         = (count_r == CW'(DEPTH));
    assign empty        = (count_r == CW'(0));
    assign almost_full  = (count_r >= CW'(AF_LEVEL));
    assign almost_empty = (count_r <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: three configurations driven in parallel and
// compared every cycle against queue-based reference models, plus literal directed checks.
module tb_fifo_param;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] d_in   = 32'h0;
    logic        wr_en  = 1'b0;
    logic        rd_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DUT 0: default, DUT 1: d_out holds, DUT 2: 16 x 8
    logic [31:0] dout0, dout1;
    logic [7:0]  dout2;
    logic [3:0]  cnt0, cnt1;
    logic [4:0]  cnt2;
    logic [2:0]  full_v, empty_v, af_v, ae_v, wack_v, werr_v, rack_v, rerr_v;

    fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .CLEAR_DOUT(1)) dut0 (
        .clk(clk), .reset(reset), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en),
        .d_out(dout0), .data_count(cnt0), .full(full_v[0]), .empty(empty_v[0]),
        .almost_full(af_v[0]), .almost_empty(ae_v[0]), .wr_ack(wack_v[0]),
        .wr_err(werr_v[0]), .rd_ack(rack_v[0]), .rd_err(rerr_v[0]));

    fifo_param #(.DATA_WIDTH(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .CLEAR_DOUT(0)) dut1 (
        .clk(clk), .reset(reset), .d_in(d_in), .wr_en(wr_en), .rd_en(rd_en),
        .d_out(dout1), .data_count(cnt1), .full(full_v[1]), .empty(empty_v[1]),
        .almost_full(af_v[1]), .almost_empty(ae_v[1]), .wr_ack(wack_v[1]),
        .wr_err(werr_v[1]), .rd_ack(rack_v[1]), .rd_err(rerr_v[1]));

    fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .CLEAR_DOUT(1)) dut2 (
        .clk(clk), .reset(reset), .d_in(d_in[7:0]), .wr_en(wr_en), .rd_en(rd_en),
        .d_out(dout2), .data_count(cnt2), .full(full_v[2]), .empty(empty_v[2]),
        .almost_full(af_v[2]), .almost_empty(ae_v[2]), .wr_ack(wack_v[2]),
        .wr_err(werr_v[2]), .rd_ack(rack_v[2]), .rd_err(rerr_v[2]));

    logic [31:0] act_dout [3];
    logic [31:0] act_cnt  [3];
    assign act_dout[0] = dout0;
    assign act_dout[1] = dout1;
    assign act_dout[2] = {24'h0, dout2};
    assign act_cnt[0]  = {28'h0, cnt0};
    assign act_cnt[1]  = {28'h0, cnt1};
    assign act_cnt[2]  = {27'h0, cnt2};

    // Reference model configuration
    int          m_depth [3] = '{8, 8, 16};
    int          m_af    [3] = '{6, 6, 12};
    int          m_ae    [3] = '{2, 2, 4};
    bit          m_clr   [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] e_dout [3] = '{32'h0, 32'h0, 32'h0};
    bit          e_wack [3];
    bit          e_werr [3];
    bit          e_rack [3];
    bit          e_rerr [3];

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic model_step(input int k, input bit we, input bit re, input logic [31:0] din);
        int cnt;
        bit rok, wok;
        logic [31:0] v;
        cnt = qsize(k);
        rok = re && (cnt != 0);
        wok = we && ((cnt != m_depth[k]) || rok);
        v = 32'h0;
        if (rok) begin
            case (k)
                0: v = q0.pop_front();
                1: v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
        end
        if (wok) begin
            case (k)
                0: q0.push_back(din & m_mask[k]);
                1: q1.push_back(din & m_mask[k]);
                default: q2.push_back(din & m_mask[k]);
            endcase
        end
        if (rok) e_dout[k] = v;
        else if (m_clr[k]) e_dout[k] = 32'h0;
        e_wack[k] = wok;
        e_werr[k] = we && !wok;
        e_rack[k] = rok;
        e_rerr[k] = re && !rok;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int k = 0; k < 3; k++) begin
                e_dout[k] = 32'h0;
                e_wack[k] = 1'b0; e_werr[k] = 1'b0; e_rack[k] = 1'b0; e_rerr[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, wr_en, rd_en, d_in);
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three DUTs against their models
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int c;
            c = qsize(k);
            chk("d_out", k, act_dout[k], e_dout[k]);
            chk("data_count", k, act_cnt[k], 32'(c));
            chk("full", k, {31'h0, full_v[k]}, {31'h0, c == m_depth[k]});
            chk("empty", k, {31'h0, empty_v[k]}, {31'h0, c == 0});
            chk("almost_full", k, {31'h0, af_v[k]}, {31'h0, c >= m_af[k]});
            chk("almost_empty", k, {31'h0, ae_v[k]}, {31'h0, c <= m_ae[k]});
            chk("wr_ack", k, {31'h0, wack_v[k]}, {31'h0, e_wack[k]});
            chk("wr_err", k, {31'h0, werr_v[k]}, {31'h0, e_werr[k]});
            chk("rd_ack", k, {31'h0, rack_v[k]}, {31'h0, e_rack[k]});
            chk("rd_err", k, {31'h0, rerr_v[k]}, {31'h0, e_rerr[k]});
        end
    end

    // Apply one request for one edge; returns just after that edge
    task automatic op(input bit we, input bit re, input logic [31:0] din);
        wr_en = we;
        rd_en = re;
        d_in  = din;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges, with immediate literal checks
    task automatic mid_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst d_out", 0, dout0, 32'h0);
        chk("rst count", 0, act_cnt[0], 32'h0);
        chk("rst empty", 0, {31'h0, empty_v[0]}, 32'h1);
        chk("rst almost_empty", 0, {31'h0, ae_v[0]}, 32'h1);
        chk("rst full", 0, {31'h0, full_v[0]}, 32'h0);
        chk("rst almost_full", 0, {31'h0, af_v[0]}, 32'h0);
        chk("rst ack/err", 0, {28'h0, wack_v[0], werr_v[0], rack_v[0], rerr_v[0]}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Build some state, then reset mid-cycle
        op(1'b1, 1'b0, 32'h5A);
        op(1'b1, 1'b0, 32'h5B);
        op(1'b1, 1'b1, 32'h5C);
        mid_reset();

        // Fill to full, then one rejected write
        for (int i = 1; i <= 8; i++) begin
            op(1'b1, 1'b0, 32'h11 * i);
            chk("fill wr_ack", 0, {31'h0, wack_v[0]}, 32'h1);
            chk("fill count", 0, act_cnt[0], 32'(i));
            chk("fill almost_empty", 0, {31'h0, ae_v[0]}, (i <= 2) ? 32'h1 : 32'h0);
            chk("fill almost_full", 0, {31'h0, af_v[0]}, (i >= 6) ? 32'h1 : 32'h0);
            chk("fill full", 0, {31'h0, full_v[0]}, (i == 8) ? 32'h1 : 32'h0);
        end
        op(1'b1, 1'b0, 32'hEE);
        chk("overflow wr_err", 0, {31'h0, werr_v[0]}, 32'h1);
        chk("overflow count", 0, act_cnt[0], 32'h8);

        // Drain with one extra read
        for (int i = 1; i <= 8; i++) begin
            op(1'b0, 1'b1, 32'h0);
            chk("drain d_out", 0, dout0, 32'h11 * i);
            chk("drain rd_ack", 0, {31'h0, rack_v[0]}, 32'h1);
        end
        op(1'b0, 1'b1, 32'h0);
        chk("underflow rd_err", 0, {31'h0, rerr_v[0]}, 32'h1);
        chk("underflow d_out", 0, dout0, 32'h0);
        chk("underflow empty", 0, {31'h0, empty_v[0]}, 32'h1);
        chk("hold d_out", 1, dout1, 32'h88);

        // Simultaneous read and write while full
        mid_reset();
        for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 32'h11 * i);
        op(1'b1, 1'b1, 32'h99);
        chk("full rw wr_ack", 0, {31'h0, wack_v[0]}, 32'h1);
        chk("full rw rd_ack", 0, {31'h0, rack_v[0]}, 32'h1);
        chk("full rw d_out", 0, dout0, 32'h11);
        chk("full rw count", 0, act_cnt[0], 32'h8);
        for (int i = 2; i <= 9; i++) begin
            op(1'b0, 1'b1, 32'h0);
            chk("full rw drain", 0, dout0, 32'h11 * i);
        end

        // Simultaneous read and write while empty
        mid_reset();
        op(1'b1, 1'b1, 32'hAB);
        chk("empty rw wr_ack", 0, {31'h0, wack_v[0]}, 32'h1);
        chk("empty rw rd_err", 0, {31'h0, rerr_v[0]}, 32'h1);
        chk("empty rw rd_ack", 0, {31'h0, rack_v[0]}, 32'h0);
        chk("empty rw count", 0, act_cnt[0], 32'h1);
        op(1'b0, 1'b1, 32'h0);
        chk("empty rw read", 0, dout0, 32'hAB);

        // Random phases alternating write-heavy and read-heavy traffic
        for (int p = 0; p < 8; p++) begin
            for (int n = 0; n < 50; n++) begin
                int pw;
                pw = (p % 2 == 0) ? 80 : 25;
                op($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (105 - pw), $urandom);
            end
        end
        op(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
